mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one unified memory port between the core's instruction-fetch port and its LSU data port, so a single-ported memory can back both. Requests are granted round-robin and held locked while the memory stalls. Each accepted request's requester ID is recorded, and every in-order memory response (`rvalid`) is routed back to the requester that issued it. The block sits between the core's `instmem_*` and `datamem_*` ports and the memory model or bus.

## Interface
Parameters:
- `Xlen`, 32, address and data width.
- `MaskBits`, `Xlen/8`, write-mask width; all-zero mask means read.
- `MaxOutstanding`, 2, depth of the response-routing ID FIFO; must be ≥1.

Ports (reset is asynchronous, active-low):
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `inst_valid_i` in 1: fetch request valid.
- `inst_ready_o` out 1: fetch request accepted this cycle.
- `inst_addr_i` in Xlen: fetch address.
- `inst_wdata_i` in Xlen: fetch write data (ignored contents, passed through).
- `inst_wmask_i` in MaskBits: fetch write mask, passed through.
- `inst_rdata_o` out Xlen: fetch response data.
- `inst_rvalid_o` out 1: fetch response valid.
- `data_valid_i`, `data_ready_o`, `data_addr_i`, `data_wdata_i`, `data_wmask_i`, `data_rdata_o`, `data_rvalid_o`: same as the `inst_*` group, for the LSU port.
- `mem_valid_o` out 1: downstream request valid.
- `mem_ready_i` in 1: downstream accepts request.
- `mem_addr_o` out Xlen: downstream address.
- `mem_wdata_o` out Xlen: downstream write data.
- `mem_wmask_o` out MaskBits: downstream write mask.
- `mem_rdata_i` in Xlen: downstream response data.
- `mem_rvalid_i` in 1: downstream response valid, exactly one per accepted request (reads and writes), in order.
- `err_o` out 1: sticky; `mem_rvalid_i` seen while no request was outstanding.

## Operation
- **States:**
  - `ArbIdle`: no pending grant.
  - `ArbLockI`: fetch request presented, not yet accepted.
  - `ArbLockD`: data request presented, not yet accepted.
- **Grant in `ArbIdle`:**
  - Only one valid: that requester wins.
  - Both valid: the requester not granted last wins, tracked by a 1-bit `rr_q`.
- **Full FIFO:** when the ID FIFO holds `MaxOutstanding` entries, no grant is made. `mem_valid_o`=0 and both readies are 0, even if a pop happens the same cycle.
- **Mux:** the granted requester's addr/wdata/wmask drive the `mem_*` outputs. `mem_valid_o` = granted requester's valid.
- **Acceptance:**
  - Handshake = `mem_valid_o && mem_ready_i`.
  - Granted requester's `*_ready_o` = `mem_ready_i`; the other's ready is 0.
  - On handshake: push the ID (0=inst, 1=data), set `rr_q` to the granted ID, go to `ArbIdle`.
- **Locking:** granted valid with no handshake → go to or stay in the matching lock state. While locked, only that requester is granted; the other waits.
- **Responses:**
  - On `mem_rvalid_i`, pop the FIFO head and assert `rvalid_o` on the head's port only.
  - `mem_rdata_i` fans out to both `*_rdata_o` unconditionally.
  - `mem_rvalid_i` with an empty FIFO: discard it, set `err_o`.
- **Simultaneous push and pop:** allowed when not full; the count is unchanged.
- **Reset mid-transaction:** FIFO is cleared, state goes to `ArbIdle`, `err_o` clears. Responses for requests accepted before reset are treated as stray (they set `err_o`).

## Timing
- Request path is combinational, zero added latency: requester valid → `mem_valid_o` in the same cycle.
- Response path is combinational: `mem_rvalid_i` → `*_rvalid_o` in the same cycle. The FIFO pop takes effect at the next edge.
- Lock and FIFO state update on `posedge clk_i`.
- Reset values:
  - State `ArbIdle`, `rr_q`=0 (data wins the first conflict), FIFO empty, `err_o`=0.
  - All `*_ready_o`, `*_rvalid_o`, and `mem_valid_o` are 0 whenever inputs are idle.
- Back-to-back throughput: one accepted request per cycle while not full. Round-robin alternates under continuous contention.

## Structure
- Put `arb_state_e` (`ArbIdle`/`ArbLockI`/`ArbLockD`) and `arb_id_e` (`ArbInst`=0, `ArbData`=1) in `core_pkg`.
- Sub-module `arb_id_fifo`: synchronous FIFO of 1-bit IDs.
  - Depth `MaxOutstanding`; ports `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - Count width `$clog2(MaxOutstanding+1)`; pointers wrap modulo depth.

## Test plan
- **Single fetch:** `inst_valid_i`=1, addr 0x100, `mem_ready_i`=1; memory returns rvalid 2 cycles later with data 0xDEADBEEF. Required: `inst_rvalid_o`=1 with `inst_rdata_o`=0xDEADBEEF, `data_rvalid_o`=0.
- **Contention after reset:** both valid, `mem_ready_i`=1 for 4 cycles. Required grant order: data, inst, data, inst; responses routed in the same order.
- **Lock under stall:** inst valid, `mem_ready_i`=0 for 3 cycles; data raises valid in cycle 1. Required: `mem_addr_o` stays on the inst address until the handshake, `data_ready_o`=0 throughout, then data is granted the next cycle.
- **Full FIFO:** `MaxOutstanding`=2, two requests accepted with no responses. Required: a third valid gets `mem_valid_o`=0. After one `mem_rvalid_i`, the next cycle grants.
- **Stray response:** `mem_rvalid_i`=1 with nothing outstanding. Required: no `*_rvalid_o`, `err_o`=1 and held until reset.
- **Reset mid-operation:** assert `rst_ni`=0 asynchronously with 1 request outstanding. Required: immediately `err_o`=0, FIFO empty, state `ArbIdle`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the instruction/data memory arbiter.
package core_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbLockI = 2'd1,
    ArbLockD = 2'd2
  } arb_state_e;

  typedef enum logic {
    ArbInst = 1'b0,
    ArbData = 1'b1
  } arb_id_e;

endpackage

// File: rtl/arb_id_fifo.sv
// Synchronous FIFO of 1-bit requester IDs used to route in-order memory responses.
module arb_id_fifo #(
  parameter int Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == FullCnt);
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = (wr_q == LastPtr) ? '0 : wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = (rd_q == LastPtr) ? '0 : rd_q + 1'b1;
    end
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and LSU, with
// lock-while-stalled grants and ID-tracked in-order response routing.
//
// state    | meaning
// ArbIdle  | no pending grant; round-robin picks among valid requesters
// ArbLockI | fetch request presented, not yet accepted
// ArbLockD | data request presented, not yet accepted
module mem_arbiter
  import core_pkg::*;
#(
  parameter int Xlen           = 32,
  parameter int MaskBits       = Xlen / 8,
  parameter int MaxOutstanding = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inst_valid_i,
  output logic                inst_ready_o,
  input  logic [Xlen-1:0]     inst_addr_i,
  input  logic [Xlen-1:0]     inst_wdata_i,
  input  logic [MaskBits-1:0] inst_wmask_i,
  output logic [Xlen-1:0]     inst_rdata_o,
  output logic                inst_rvalid_o,
  input  logic                data_valid_i,
  output logic                data_ready_o,
  input  logic [Xlen-1:0]     data_addr_i,
  input  logic [Xlen-1:0]     data_wdata_i,
  input  logic [MaskBits-1:0] data_wmask_i,
  output logic [Xlen-1:0]     data_rdata_o,
  output logic                data_rvalid_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [Xlen-1:0]     mem_addr_o,
  output logic [Xlen-1:0]     mem_wdata_o,
  output logic [MaskBits-1:0] mem_wmask_o,
  input  logic [Xlen-1:0]     mem_rdata_i,
  input  logic                mem_rvalid_i,
  output logic                err_o
);

  arb_state_e state_q, state_d;
  arb_id_e    rr_q, rr_d;
  arb_id_e    gnt_id;
  logic       gnt_en;
  logic       err_q, err_d;
  logic       handshake;
  logic       fifo_full, fifo_empty, fifo_head;

  // A full ID FIFO blocks every grant, regardless of a same-cycle pop.
  always_comb begin
    gnt_en = 1'b0;
    gnt_id = ArbInst;
    if (!fifo_full) begin
      case (state_q)
        ArbLockI: begin
          gnt_en = inst_valid_i;
          gnt_id = ArbInst;
        end
        ArbLockD: begin
          gnt_en = data_valid_i;
          gnt_id = ArbData;
        end
        default: begin
          if (inst_valid_i && data_valid_i) begin
            gnt_en = 1'b1;
            gnt_id = (rr_q == ArbInst) ? ArbData : ArbInst;
          end else if (inst_valid_i) begin
            gnt_en = 1'b1;
            gnt_id = ArbInst;
          end else if (data_valid_i) begin
            gnt_en = 1'b1;
            gnt_id = ArbData;
          end
        end
      endcase
    end
  end

  assign handshake    = gnt_en && mem_ready_i;
  assign mem_valid_o  = gnt_en;
  assign mem_addr_o   = (gnt_id == ArbData) ? data_addr_i  : inst_addr_i;
  assign mem_wdata_o  = (gnt_id == ArbData) ? data_wdata_i : inst_wdata_i;
  assign mem_wmask_o  = (gnt_id == ArbData) ? data_wmask_i : inst_wmask_i;
  assign inst_ready_o = gnt_en && (gnt_id == ArbInst) && mem_ready_i;
  assign data_ready_o = gnt_en && (gnt_id == ArbData) && mem_ready_i;

  assign inst_rdata_o  = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign inst_rvalid_o = mem_rvalid_i && !fifo_empty && (fifo_head == ArbInst);
  assign data_rvalid_o = mem_rvalid_i && !fifo_empty && (fifo_head == ArbData);
  assign err_o         = err_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (handshake) begin
      state_d = ArbIdle;
      rr_d    = gnt_id;
    end else if (gnt_en) begin
      state_d = (gnt_id == ArbData) ? ArbLockD : ArbLockI;
    end else if (!fifo_full) begin
      state_d = ArbIdle;
    end
    err_d = err_q || (mem_rvalid_i && fifo_empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ArbIdle;
      rr_q    <= ArbInst;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  arb_id_fifo #(
    .Depth(MaxOutstanding)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (handshake),
    .pop   (mem_rvalid_i),
    .din   (gnt_id),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and scripted stimulus for mem_arbiter, checked against a
// transaction-level model (outstanding-ID queue, last-winner bit, pending lock).
module tb_mem_arbiter;

  localparam int XL  = 32;
  localparam int MB  = 4;
  localparam int MAX = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          inst_valid = 1'b0, data_valid = 1'b0;
  logic          inst_ready, data_ready;
  logic [XL-1:0] inst_addr = '0, inst_wdata = '0, data_addr = '0, data_wdata = '0;
  logic [MB-1:0] inst_wmask = '0, data_wmask = '0;
  logic [XL-1:0] inst_rdata, data_rdata;
  logic          inst_rvalid, data_rvalid;
  logic          mem_valid;
  logic          mem_ready = 1'b0;
  logic [XL-1:0] mem_addr, mem_wdata;
  logic [MB-1:0] mem_wmask;
  logic [XL-1:0] mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic          err;

  always #5 clk = ~clk;

  mem_arbiter #(.Xlen(XL), .MaskBits(MB), .MaxOutstanding(MAX)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .inst_valid_i(inst_valid), .inst_ready_o(inst_ready), .inst_addr_i(inst_addr),
    .inst_wdata_i(inst_wdata), .inst_wmask_i(inst_wmask), .inst_rdata_o(inst_rdata),
    .inst_rvalid_o(inst_rvalid),
    .data_valid_i(data_valid), .data_ready_o(data_ready), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_wmask_i(data_wmask), .data_rdata_o(data_rdata),
    .data_rvalid_o(data_rvalid),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata),
    .mem_rvalid_i(mem_rvalid), .err_o(err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: IDs awaiting responses, last winner, who holds the lock.
  bit mq[$];
  bit m_rr  = 1'b0;
  int m_lock = -1;
  bit m_err = 1'b0;
  bit i_hold = 1'b0, d_hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit iv, input bit dv, input bit rdy, input bit rv);
    int  g;
    bit  full;
    bit  has_head;
    bit  head;
    if (!i_hold) begin
      inst_valid = iv; inst_addr = $urandom; inst_wdata = $urandom; inst_wmask = MB'($urandom);
    end
    if (!d_hold) begin
      data_valid = dv; data_addr = $urandom; data_wdata = $urandom; data_wmask = MB'($urandom);
    end
    mem_ready  = rdy;
    mem_rvalid = rv;
    mem_rdata  = $urandom;

    full     = (mq.size() == MAX);
    has_head = (mq.size() > 0);
    head     = has_head ? mq[0] : 1'b0;
    g = -1;
    if (!full) begin
      if (m_lock == 0) begin
        if (inst_valid) g = 0;
      end else if (m_lock == 1) begin
        if (data_valid) g = 1;
      end else if (inst_valid && data_valid) g = m_rr ? 0 : 1;
      else if (inst_valid) g = 0;
      else if (data_valid) g = 1;
    end

    @(negedge clk);
    chk("mem_valid", 32'(mem_valid), 32'(g >= 0));
    if (g >= 0) begin
      chk("mem_addr",  mem_addr,  (g == 1) ? data_addr  : inst_addr);
      chk("mem_wdata", mem_wdata, (g == 1) ? data_wdata : inst_wdata);
      chk("mem_wmask", 32'(mem_wmask), 32'((g == 1) ? data_wmask : inst_wmask));
    end
    chk("inst_ready",  32'(inst_ready),  32'(g == 0 && rdy));
    chk("data_ready",  32'(data_ready),  32'(g == 1 && rdy));
    chk("inst_rvalid", 32'(inst_rvalid), 32'(rv && has_head && head == 1'b0));
    chk("data_rvalid", 32'(data_rvalid), 32'(rv && has_head && head == 1'b1));
    chk("inst_rdata",  inst_rdata, mem_rdata);
    chk("data_rdata",  data_rdata, mem_rdata);
    chk("err",         32'(err), 32'(m_err));

    @(posedge clk);
    if (rv) begin
      if (has_head) void'(mq.pop_front());
      else m_err = 1'b1;
    end
    if (g >= 0 && rdy) begin
      mq.push_back(g[0]);
      m_rr   = g[0];
      m_lock = -1;
    end else if (g >= 0) m_lock = g;
    else if (!full) m_lock = -1;
    i_hold = inst_valid && !(g == 0 && rdy);
    d_hold = data_valid && !(g == 1 && rdy);
    #1;
  endtask

  task automatic async_reset();
    inst_valid = 1'b0; data_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    i_hold = 1'b0; d_hold = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_err",        32'(err),        32'(0));
    chk("rst_mem_valid",  32'(mem_valid),  32'(0));
    chk("rst_inst_ready", 32'(inst_ready), 32'(0));
    chk("rst_data_ready", 32'(data_ready), 32'(0));
    mq.delete();
    m_lock = -1; m_rr = 1'b0; m_err = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (mq.size() > 0 || i_hold || d_hold); k++)
      step(1'b0, 1'b0, 1'b1, mq.size() > 0);
  endtask

  task automatic random_phase(input int cycles, input int pi, input int pd,
                              input int pr, input int pv);
    for (int c = 0; c < cycles; c++)
      step($urandom_range(99) < pi, $urandom_range(99) < pd, $urandom_range(99) < pr,
           mq.size() > 0 && $urandom_range(99) < pv);
  endtask

  initial begin
    async_reset();
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    // single fetch, response two cycles later
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // contention right after reset: data first, then alternating
    async_reset();
    step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    drain();

    // lock under stall
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    drain();

    // full ID FIFO blocks grants even with a same-cycle pop
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    step(1, 1, 1, 0);
    drain();

    // stray response sets a sticky error
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);

    // reset with one request outstanding; its late response is stray
    async_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    async_reset();

    random_phase(400, 60, 60, 50, 50);
    async_reset();
    random_phase(400, 90, 90, 30, 30);
    async_reset();
    random_phase(400, 40, 70, 80, 70);
    step(0, 0, 0, mq.size() == 0);
    random_phase(200, 50, 50, 50, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
